// File: rtl/matmul_mem_subsys.sv
// matmul_mem_subsys: A/B/C row banks for the systolic matmul core.
// The host owns the banks while idle; a run streams A/B rows to the core
// and captures the returned C rows, then pulses done.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | host may load/unload banks; waiting for start
// STREAM | issuing A/B row addresses 0..num_rows-1, one per cycle
// DRAIN  | all addresses issued; waiting for read pipe and C rows
// DONE   | one-cycle completion pulse, then back to IDLE
module matmul_mem_subsys #(
  parameter int DWIDTH   = 16,
  parameter int N        = 4,
  parameter int AWIDTH   = 7,
  parameter int MEM_SIZE = 128
) (
  input  logic                clk_mem,
  input  logic                reset,
  input  logic                host_we,
  input  logic                host_re,
  input  logic [1:0]          host_sel,
  input  logic [AWIDTH-1:0]   host_addr,
  input  logic [N*DWIDTH-1:0] host_wdata,
  output logic [N*DWIDTH-1:0] host_rdata,
  output logic                host_rvalid,
  output logic                host_err,
  input  logic                start,
  input  logic [AWIDTH:0]     num_rows,
  output logic                busy,
  output logic                done,
  output logic [N*DWIDTH-1:0] a_out,
  output logic [N*DWIDTH-1:0] b_out,
  output logic                ab_valid,
  input  logic [N*DWIDTH-1:0] c_in,
  input  logic                c_in_valid,
  output logic                c_overflow
);
  localparam int W = N * DWIDTH;
  localparam logic [AWIDTH:0] MAX_ROWS = (AWIDTH+1)'(MEM_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [AWIDTH:0]   nrows_q, nrows_eff;
  logic [AWIDTH-1:0] rp_q;
  logic [AWIDTH:0]   wp_q;
  logic [AWIDTH-1:0] addr_q;
  logic [W-1:0]      wdata_q;
  logic [2:0]        we_q;
  logic              hre1_q, hre2_q;
  logic [1:0]        hsel1_q, hsel2_q;
  logic              sv1_q, sv2_q;
  logic [W-1:0]      a_rd_q, b_rd_q, c_rd_q;
  logic [W-1:0]      mem_a [MEM_SIZE];
  logic [W-1:0]      mem_b [MEM_SIZE];
  logic [W-1:0]      mem_c [MEM_SIZE];

  logic start_acc, cap_act, wp_full, cap_we, host_req, host_acc, last_issue;
  logic [AWIDTH-1:0] c_addr;
  logic              c_wr;
  logic [W-1:0]      c_wd;

  assign nrows_eff  = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
  assign start_acc  = (state_q == S_IDLE) && start;
  assign cap_act    = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign wp_full    = (wp_q == nrows_q);
  // The reset gate keeps a C word arriving on the reset edge out of the bank.
  assign cap_we     = cap_act && c_in_valid && !wp_full && !reset;
  assign host_req   = host_we || host_re;
  assign host_acc   = (state_q == S_IDLE) && host_req && (host_sel != 2'd3);
  assign last_issue = ({1'b0, rp_q} == (nrows_q - (AWIDTH+1)'(1)));

  // C bank port is shared: capture owns it while running, host otherwise.
  assign c_addr = cap_we ? wp_q[AWIDTH-1:0] : addr_q;
  assign c_wr   = cap_we || we_q[2];
  assign c_wd   = cap_we ? c_in : wdata_q;

  // State register
  always_ff @(posedge clk_mem) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; DRAIN also waits for the A/B read pipe to empty so
  // done never overlaps the last ab_valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (nrows_eff == '0) ? S_DONE : S_STREAM;
      S_STREAM: if (last_issue) state_d = S_DRAIN;
      S_DRAIN:  if (wp_full && !sv1_q && !sv2_q) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // Run bookkeeping: row count, read/write pointers, overflow flag
  always_ff @(posedge clk_mem) begin
    if (reset) begin
      nrows_q    <= '0;
      rp_q       <= '0;
      wp_q       <= '0;
      c_overflow <= 1'b0;
    end else if (start_acc) begin
      nrows_q    <= nrows_eff;
      rp_q       <= '0;
      wp_q       <= '0;
      c_overflow <= 1'b0;
    end else begin
      if (state_q == S_STREAM) rp_q <= rp_q + AWIDTH'(1);
      if (cap_we) wp_q <= wp_q + (AWIDTH+1)'(1);
      if (cap_act && c_in_valid && wp_full) c_overflow <= 1'b1;
    end
  end

  // Address/strobe registers and the host and stream output pipelines
  always_ff @(posedge clk_mem) begin
    if (reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= '0;
      hre1_q      <= 1'b0;
      hre2_q      <= 1'b0;
      hsel1_q     <= '0;
      hsel2_q     <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      host_err    <= 1'b0;
      sv1_q       <= 1'b0;
      sv2_q       <= 1'b0;
      ab_valid    <= 1'b0;
      a_out       <= '0;
      b_out       <= '0;
    end else begin
      if (state_q == S_STREAM) addr_q <= rp_q;
      else if (host_acc)       addr_q <= host_addr;
      wdata_q  <= host_wdata;
      we_q[0]  <= host_acc && host_we && (host_sel == 2'd0);
      we_q[1]  <= host_acc && host_we && (host_sel == 2'd1);
      we_q[2]  <= host_acc && host_we && (host_sel == 2'd2);
      hre1_q   <= host_acc && host_re && !host_we;
      hsel1_q  <= host_sel;
      hre2_q   <= hre1_q;
      hsel2_q  <= hsel1_q;
      if (hre2_q) begin
        case (hsel2_q)
          2'd0:    host_rdata <= a_rd_q;
          2'd1:    host_rdata <= b_rd_q;
          default: host_rdata <= c_rd_q;
        endcase
      end
      host_rvalid <= hre2_q;
      host_err    <= host_req && ((state_q != S_IDLE) || (host_sel == 2'd3));
      sv1_q       <= (state_q == S_STREAM);
      sv2_q       <= sv1_q;
      ab_valid    <= sv2_q;
      if (sv2_q) begin
        a_out <= a_rd_q;
        b_out <= b_rd_q;
      end
    end
  end

  // Bank A: single-port, registered address, synchronous read
  always_ff @(posedge clk_mem) begin
    if (we_q[0]) mem_a[addr_q] <= wdata_q;
    a_rd_q <= mem_a[addr_q];
  end

  // Bank B: single-port, registered address, synchronous read
  always_ff @(posedge clk_mem) begin
    if (we_q[1]) mem_b[addr_q] <= wdata_q;
    b_rd_q <= mem_b[addr_q];
  end

  // Bank C: capture writes land on the edge they are sampled
  always_ff @(posedge clk_mem) begin
    if (c_wr) mem_c[c_addr] <= c_wd;
    c_rd_q <= mem_c[c_addr];
  end

endmodule

// File: tb/tb_matmul_mem_subsys.sv
// Bench for matmul_mem_subsys: directed runs; host reads and A/B row streams
// are checked by a scoreboard monitor sampling on the falling edge.
module tb_matmul_mem_subsys;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int AW = 7;
  localparam int MS = 128;
  localparam int W  = N * DW;

  logic          clk_mem = 1'b0;
  logic          reset = 1'b1;
  logic          host_we = 1'b0, host_re = 1'b0;
  logic [1:0]    host_sel = '0;
  logic [AW-1:0] host_addr = '0;
  logic [W-1:0]  host_wdata = '0;
  logic [W-1:0]  host_rdata;
  logic          host_rvalid, host_err;
  logic          start = 1'b0;
  logic [AW:0]   num_rows = '0;
  logic          busy, done;
  logic [W-1:0]  a_out, b_out;
  logic          ab_valid;
  logic [W-1:0]  c_in = '0;
  logic          c_in_valid = 1'b0;
  logic          c_overflow;

  matmul_mem_subsys #(.DWIDTH(DW), .N(N), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
    .clk_mem(clk_mem), .reset(reset),
    .host_we(host_we), .host_re(host_re), .host_sel(host_sel),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_err(host_err),
    .start(start), .num_rows(num_rows), .busy(busy), .done(done),
    .a_out(a_out), .b_out(b_out), .ab_valid(ab_valid),
    .c_in(c_in), .c_in_valid(c_in_valid), .c_overflow(c_overflow)
  );

  always #5 clk_mem = ~clk_mem;

  typedef struct { logic [W-1:0] data; int cyc; } rd_exp_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; int cyc; } ab_exp_t;

  rd_exp_t      rd_q[$];
  ab_exp_t      ab_q[$];
  rd_exp_t      rd_e;
  ab_exp_t      ab_e;
  logic [W-1:0] a_mdl [MS];
  logic [W-1:0] b_mdl [MS];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic         mon_en = 1'b0;

  always @(posedge clk_mem) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [15:0] x);
    return {N{x}};
  endfunction

  task automatic tick();
    @(posedge clk_mem);
    #1;
  endtask

  task automatic host_write(input logic [1:0] sel, input int addr, input logic [W-1:0] data);
    host_we = 1'b1; host_sel = sel; host_addr = AW'(addr); host_wdata = data;
    tick();
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [1:0] sel, input int addr, input logic [W-1:0] exp);
    rd_exp_t e;
    host_re = 1'b1; host_sel = sel; host_addr = AW'(addr);
    tick();
    host_re = 1'b0;
    e.data = exp; e.cyc = cyc + 2;
    rd_q.push_back(e);
  endtask

  // Rows are expected 3 cycles after the start edge, back to back, clamped to MS.
  task automatic start_run(input int n, output int t0);
    ab_exp_t e;
    int m;
    start = 1'b1; num_rows = (AW+1)'(n);
    tick();
    start = 1'b0;
    t0 = cyc;
    m = (n > MS) ? MS : n;
    for (int k = 0; k < m; k++) begin
      e.a = a_mdl[k]; e.b = b_mdl[k]; e.cyc = t0 + 3 + k;
      ab_q.push_back(e);
    end
  endtask

  task automatic feed_c(input int n, input logic [W-1:0] base, input int gap);
    for (int k = 0; k < n; k++) begin
      c_in = base + W'(k); c_in_valid = 1'b1;
      tick();
      c_in_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  // Watches a fixed window: exactly one done pulse, busy low the cycle after.
  task automatic wait_done(input int budget, output int first);
    int   cnt;
    logic busy_after;
    cnt = 0; first = -1; busy_after = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (first >= 0 && cyc == first + 1) busy_after = busy;
      if (done) begin
        cnt++;
        if (first < 0) first = cyc;
      end
      tick();
    end
    check("done_pulse_count", 64'(cnt), 64'(1));
    check("busy_after_done", {63'd0, busy_after}, 64'(0));
  endtask

  always @(negedge clk_mem) begin
    if (mon_en) begin
      if (host_rvalid) begin
        if (rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected actual rvalid with rdata=%h required=no rvalid", host_rdata);
        end else begin
          rd_e = rd_q.pop_front();
          check("host_rdata", host_rdata, rd_e.data);
          check("host_rd_cycle", 64'(cyc), 64'(rd_e.cyc));
        end
      end
      if (ab_valid) begin
        if (ab_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL ab_unexpected actual ab_valid with a_out=%h required=no ab_valid", a_out);
        end else begin
          ab_e = ab_q.pop_front();
          check("a_out", a_out, ab_e.a);
          check("b_out", b_out, ab_e.b);
          check("ab_cycle", 64'(cyc), 64'(ab_e.cyc));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, td;
    logic [W-1:0] kc;

    repeat (3) tick();
    check("rst_host_rdata", host_rdata, '0);
    check("rst_host_rvalid", {63'd0, host_rvalid}, '0);
    check("rst_host_err", {63'd0, host_err}, '0);
    check("rst_busy", {63'd0, busy}, '0);
    check("rst_done", {63'd0, done}, '0);
    check("rst_a_out", a_out, '0);
    check("rst_b_out", b_out, '0);
    check("rst_ab_valid", {63'd0, ab_valid}, '0);
    check("rst_c_overflow", {63'd0, c_overflow}, '0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    for (int i = 0; i < MS; i++) begin
      a_mdl[i] = rep(16'(i)); host_write(2'd0, i, a_mdl[i]);
      b_mdl[i] = rep(16'(i)); host_write(2'd1, i, b_mdl[i]);
    end
    host_read(2'd0, 2, rep(16'd2));
    host_read(2'd1, 127, rep(16'd127));
    repeat (3) tick();

    // Run 1: 4 rows, C returned at 2-cycle gaps; done at t0+8.
    start_run(4, t0);
    check("busy_after_start", {63'd0, busy}, 64'(1));
    feed_c(4, 64'hAAAA_AAAA_AAAA_AAAA, 1);
    wait_done(20, td);
    check("done_cycle", 64'(td), 64'(t0 + 8));
    for (int k = 0; k < 4; k++) host_read(2'd2, k, 64'hAAAA_AAAA_AAAA_AAAA + W'(k));
    repeat (3) tick();

    // Run 2: 5 C words for 4 rows -> overflow, C[4] untouched; distinct B rows.
    kc = 64'h1234_5678_9ABC_DEF0;
    host_write(2'd2, 4, kc);
    for (int i = 0; i < 4; i++) begin
      b_mdl[i] = rep(16'h0B00 + 16'(i)); host_write(2'd1, i, b_mdl[i]);
    end
    start_run(4, t0);
    feed_c(5, 64'h5000, 0);
    wait_done(20, td);
    check("c_overflow_set", {63'd0, c_overflow}, 64'(1));
    host_read(2'd2, 4, kc);
    host_read(2'd2, 0, 64'h5000);
    host_read(2'd2, 3, 64'h5003);
    repeat (3) tick();
    start_run(2, t0);
    check("c_overflow_cleared", {63'd0, c_overflow}, 64'(0));
    feed_c(2, 64'h6000, 0);
    wait_done(20, td);

    // Run 3: host write and start while busy.
    start_run(8, t0);
    host_write(2'd0, 0, rep(16'hDEAD));
    check("err_write_busy", {63'd0, host_err}, 64'(1));
    start = 1'b1; num_rows = (AW+1)'(3);
    tick();
    start = 1'b0;
    check("no_err_start_busy", {63'd0, host_err}, 64'(0));
    feed_c(8, 64'h7000, 0);
    wait_done(20, td);
    host_read(2'd0, 0, a_mdl[0]);

    // Reserved bank, simultaneous we/re, write-then-read next cycle.
    host_write(2'd3, 9, rep(16'hBEEF));
    check("err_sel3", {63'd0, host_err}, 64'(1));
    host_we = 1'b1; host_re = 1'b1; host_sel = 2'd0; host_addr = AW'(5);
    host_wdata = rep(16'h5555);
    tick();
    host_we = 1'b0; host_re = 1'b0;
    a_mdl[5] = rep(16'h5555);
    check("no_err_we_re", {63'd0, host_err}, 64'(0));
    host_read(2'd0, 5, a_mdl[5]);
    b_mdl[6] = rep(16'h6666);
    host_write(2'd1, 6, b_mdl[6]);
    host_read(2'd1, 6, b_mdl[6]);
    repeat (3) tick();

    // num_rows=0: done in the cycle right after start, no rows.
    start_run(0, t0);
    check("zero_done", {63'd0, done}, 64'(1));
    check("zero_busy", {63'd0, busy}, 64'(1));
    tick();
    check("zero_done_fall", {63'd0, done}, 64'(0));
    check("zero_busy_fall", {63'd0, busy}, 64'(0));

    // num_rows=200 clamps to 128 rows.
    start_run(200, t0);
    feed_c(128, 64'h8000, 0);
    wait_done(30, td);

    // Reset in the middle of a stream.
    start_run(8, t0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    ab_q.delete();
    check("mid_rst_ab_valid", {63'd0, ab_valid}, '0);
    check("mid_rst_a_out", a_out, '0);
    check("mid_rst_b_out", b_out, '0);
    check("mid_rst_busy", {63'd0, busy}, '0);
    check("mid_rst_done", {63'd0, done}, '0);
    check("mid_rst_host_rdata", host_rdata, '0);
    check("mid_rst_rvalid", {63'd0, host_rvalid}, '0);
    check("mid_rst_err", {63'd0, host_err}, '0);
    check("mid_rst_overflow", {63'd0, c_overflow}, '0);
    reset = 1'b0;
    tick();
    start_run(3, t0);
    feed_c(3, 64'h9000, 0);
    wait_done(20, td);
    host_read(2'd2, 2, 64'h9002);
    repeat (5) tick();

    check("rd_queue_drained", 64'(rd_q.size()), 64'(0));
    check("ab_queue_drained", 64'(ab_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_mem_subsys.md
# matmul_mem_subsys

Parametrised memory subsystem for the systolic matmul datapath: it holds matrix A, B and C banks as N-lane-wide words. The host loads and unloads the banks through one shared port. An FSM streams A/B rows to the compute core and captures the C rows the core returns. It generalises the fixed 4x4 fp16 memory top to arbitrary lane count, data width and depth, and adds start/done sequencing, back-pressure-free capture accounting and host-access protection while busy.

## Interface
- DWIDTH, 16, bits per element
- N, 4, lanes (elements) per memory word
- AWIDTH, 7, address bits per bank
- MEM_SIZE, 128, words per bank (≤ 2^AWIDTH)

Ports:
- clk_mem  in  1  clock for all logic and RAMs
- reset  in  1  reset, synchronous, active-high
- host_we  in  1  host write strobe
- host_re  in  1  host read strobe
- host_sel  in  2  bank select: 0=A, 1=B, 2=C, 3=reserved (access ignored)
- host_addr  in  AWIDTH  host word address
- host_wdata  in  N*DWIDTH  host write data
- host_rdata  out  N*DWIDTH  host read data (held until next read)
- host_rvalid  out  1  one-cycle pulse, host_rdata valid
- host_err  out  1  one-cycle pulse: host access rejected
- start  in  1  start pulse, accepted only in IDLE
- num_rows  in  AWIDTH+1  rows to stream; sampled at accepted start
- busy  out  1  high from STREAM through DONE
- done  out  1  one-cycle pulse on completion
- a_out, b_out  out  N*DWIDTH  row streams to core
- ab_valid  out  1  a_out/b_out valid this cycle
- c_in  in  N*DWIDTH  result row from core
- c_in_valid  in  1  c_in valid this cycle
- c_overflow  out  1  sticky: C word arrived beyond num_rows; cleared by reset or accepted start

## Operation
- Three single-port synchronous-read RAMs, MEM_SIZE × N*DWIDTH; contents not cleared by reset.
- FSM: IDLE -> STREAM on start (num_rows>0); IDLE -> DONE on start with num_rows=0. STREAM -> DRAIN after address num_rows-1 issued. DRAIN -> DONE when the C capture count equals num_rows. DONE -> IDLE after one cycle (done=1 in DONE).
- num_rows > MEM_SIZE is clamped to MEM_SIZE.
- STREAM: read pointer rp issues A and B address rp (0,1,...), one per cycle, no gaps.
- C capture is active in STREAM and DRAIN. Each c_in_valid writes c_in to C[wp]; wp increments. Once wp = num_rows, further c_in_valid are dropped and set c_overflow. c_in_valid in IDLE/DONE is dropped without a flag.
- Host access is allowed in IDLE only. host_we or host_re while busy -> dropped and host_err pulses the next cycle. A sel=3 access also pulses host_err.
- Simultaneous host_we and host_re: write performed, read ignored, no rvalid, no err.
- start while busy: ignored, no err.
- Reset mid-operation: FSM -> IDLE, pointers 0. Pending ab_valid/host_rvalid pipeline is flushed.

## Timing
- Reset values: host_rdata=0, host_rvalid=0, host_err=0, busy=0, done=0, a_out=b_out=0, ab_valid=0, c_overflow=0.
- Start accepted at edge T: busy=1 after T. Address 0 is registered at T+1, RAM data at T+2, output registers at T+3. ab_valid first high after edge T+3, for exactly num_rows consecutive cycles.
- Host read at edge T: host_rdata/host_rvalid after edge T+2. A write at edge T is visible to a read issued at T+1.
- c_in written at the edge it is sampled. done rises the cycle after the last required C write is sampled, with a minimum of one cycle after the last ab_valid.
- busy falls together with done falling (IDLE entered).

## Test plan
- Load A[i]=B[i]=i (lane-replicated), num_rows=4, start -> ab_valid high for 4 consecutive cycles starting 3 cycles after start; a_out = 0,1,2,3.
- Core model returns 4 C words (0xAAAA…+k) at 2-cycle gaps -> done pulses once, busy low next cycle; host reads of C[0..3] return the values at rvalid, 2 cycles after each read.
- Feed 5 C words with num_rows=4 -> C[4] unchanged, c_overflow=1; next start clears it.
- Host write to A during STREAM -> host_err pulse, A unchanged; start during busy ignored.
- num_rows=0 -> done one cycle after start, no ab_valid; num_rows=200 -> clamped, exactly 128 ab_valid cycles.
- Assert reset mid-STREAM -> all outputs return to reset values next cycle; a subsequent start runs normally.
